// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack CDC handshake: captures a word on valid/ready,
// holds it on cdc_data with cdc_req high until the resynchronised ack completes the cycle.
module cdc_handshake_tx #(
  parameter int unsigned C_DATA_WIDTH  = 32,
  parameter int unsigned C_SYNC_STAGES = 3,
  parameter int unsigned C_TIMEOUT     = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [C_DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    cdc_req,
  output logic [C_DATA_WIDTH-1:0] cdc_data,
  input  logic                    cdc_ack,
  output logic                    busy,
  input  logic                    err_clr,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W = (C_TIMEOUT == 0) ? 1 : $clog2(C_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((C_TIMEOUT == 0) ? 0 : C_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_ACK_LOW = 2'd2;

  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [C_SYNC_STAGES-1:0] ack_sync_q;
  logic                     ack_s;

  logic [1:0]              state_q, state_d;
  logic                    req_q, req_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    ready_c;

  // cdc_ack is only ever observed through this chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[C_SYNC_STAGES-2:0], cdc_ack};
    end
  end

  assign ack_s   = ack_sync_q[C_SYNC_STAGES-1];
  assign ready_c = (state_q == S_IDLE) && !ack_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_valid && ready_c) begin
          data_d  = s_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // ack takes priority over a timeout landing in the same cycle
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_ACK_LOW;
        end else if ((C_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ACK_LOW;
        end else if (C_TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK_LOW: begin
        if (!ack_s) state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign s_ready     = ready_c;
  assign busy        = (state_q != S_IDLE);
  assign cdc_req     = req_q;
  assign cdc_data    = data_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomised and directed bench for cdc_handshake_tx with a protocol-level source model
// and a destination-domain responder running on an unrelated clock.
module tb_cdc_handshake_tx;

  localparam int unsigned DW   = 32;
  localparam int unsigned SYNC = 3;
  localparam int unsigned TMO  = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          cdc_req;
  logic [DW-1:0] cdc_data;
  logic          cdc_ack;
  logic          busy;
  logic          err_clr;
  logic          timeout_err;

  logic ack_dir = 1'b0;
  logic ack_dst = 1'b0;
  logic dest_en = 1'b0;
  logic dclk    = 1'b0;
  int   dhalf   = 18;

  int n_chk  = 0;
  int n_pass = 0;
  int n_rx   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_log[$];

  assign cdc_ack = dest_en ? ack_dst : ack_dir;

  cdc_handshake_tx #(
    .C_DATA_WIDTH (DW),
    .C_SYNC_STAGES(SYNC),
    .C_TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cdc_req    (cdc_req),
    .cdc_data   (cdc_data),
    .cdc_ack    (cdc_ack),
    .busy       (busy),
    .err_clr    (err_clr),
    .timeout_err(timeout_err)
  );

  // clk edges fall on even times, destination edges on odd times: no sampling races
  always #50 clk = ~clk;

  initial begin
    #1;
    forever begin
      #(dhalf) dclk = ~dclk;
    end
  end

  initial begin
    #9000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol-level source model: one outstanding transfer, released once the
  // delayed view of ack has gone high and then low again.
  logic [SYNC-1:0] hist = '0;
  bit              m_inflight, m_drain, m_req, m_err;
  logic [DW-1:0]   m_data;
  int unsigned     m_wait;

  always @(posedge clk) begin : model
    logic          acks, v, clr, a, prev_req;
    logic [DW-1:0] d;
    bit            rdy, timed;
    acks = hist[SYNC-1];
    v = s_valid; d = s_data; clr = err_clr; a = cdc_ack; prev_req = cdc_req;
    timed = 1'b0;
    if (!rstn) begin
      hist = '0; m_inflight = 0; m_drain = 0; m_req = 0; m_err = 0; m_data = '0; m_wait = 0;
    end else begin
      rdy = !m_inflight && !m_drain && !acks;
      if (!m_inflight && !m_drain) begin
        if (v && rdy) begin
          m_data = d; m_req = 1; m_inflight = 1; m_wait = 0;
          if (dest_en) exp_q.push_back(d);
        end
      end else if (m_inflight) begin
        if (acks) begin
          m_req = 0; m_inflight = 0; m_drain = 1;
        end else if (m_wait == TMO - 1) begin
          m_req = 0; m_inflight = 0; m_drain = 1; timed = 1;
        end else begin
          m_wait++;
        end
      end else if (!acks) begin
        m_drain = 0;
      end
      if (timed) m_err = 1;
      else if (clr) m_err = 0;
      hist = {hist[SYNC-2:0], a};
    end
    #1;
    chk("m_cdc_req", 64'(cdc_req), 64'(m_req));
    chk("m_cdc_data", 64'(cdc_data), 64'(m_data));
    chk("m_busy", 64'(busy), 64'(m_inflight || m_drain));
    chk("m_s_ready", 64'(s_ready), 64'(!m_inflight && !m_drain && !hist[SYNC-1]));
    chk("m_timeout_err", 64'(timeout_err), 64'(m_err));
    if (rstn && cdc_req && !prev_req) chk("req_rise_while_ack_s", 64'(acks), 64'(0));
  end

  // Destination responder: two-flop req synchroniser, captures on req seen, acks until req drops
  logic [1:0] rs = 2'b00;
  always @(posedge dclk) begin
    if (!dest_en || !rstn) begin
      rs = 2'b00;
      ack_dst = 1'b0;
    end else begin
      rs = {rs[0], cdc_req};
      if (rs[1] && !ack_dst) begin
        n_rx++;
        rx_log.push_back(cdc_data);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rx_spurious: got word 0x%0h expected none", cdc_data);
        end else begin
          chk("rx_word", 64'(cdc_data), 64'(exp_q.pop_front()));
        end
        ack_dst = 1'b1;
      end else if (!rs[1] && ack_dst) begin
        ack_dst = 1'b0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] w, input bit scramble, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 500) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = (scramble && !s_ready) ? DW'($urandom) : w;
      if (s_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 500 cycles", w);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || cdc_ack || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      n_chk++;
      $display("FAIL %s: block still busy after 3000 cycles", name);
    end
  endtask

  initial begin
    int n;
    int base;
    bit ok;
    bit abort;
    abort = 1'b0;
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_s_ready_release", 64'(s_ready), 64'(1));
    tick();
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_cdc_req", 64'(cdc_req), 64'(0));
    chk("rst_cdc_data", 64'(cdc_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));

    // basic transfer driven by hand
    send(32'hDEADBEEF, 1'b0, ok);
    chk("basic_req", 64'(cdc_req), 64'(1));
    chk("basic_data", 64'(cdc_data), 64'hDEADBEEF);
    chk("basic_busy", 64'(busy), 64'(1));
    @(negedge clk); s_valid = 1'b0; s_data = 32'h12345678;
    repeat (2) @(negedge clk);
    ack_dir = 1'b1;
    n = 0;
    do begin tick(); n++; end while (cdc_req && n < 20);
    chk("basic_req_fall_edges", 64'(n), 64'(4));
    chk("basic_data_held", 64'(cdc_data), 64'hDEADBEEF);
    repeat (2) @(negedge clk);
    ack_dir = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!s_ready && n < 20);
    chk("basic_ready_edges", 64'(n), 64'(4));
    chk("basic_busy_end", 64'(busy), 64'(0));

    // timeout with ack never asserted
    send(32'h0000CAFE, 1'b0, ok);
    @(negedge clk); s_valid = 1'b0;
    n = 1;
    while (n < 40) begin
      tick();
      if (cdc_req) n++;
      else break;
    end
    chk("tmo_req_cycles", 64'(n), 64'(16));
    chk("tmo_err_set", 64'(timeout_err), 64'(1));
    chk("tmo_busy_ack_low", 64'(busy), 64'(1));
    tick();
    chk("tmo_idle_busy", 64'(busy), 64'(0));
    chk("tmo_idle_ready", 64'(s_ready), 64'(1));

    // late ack after the abort
    @(negedge clk); ack_dir = 1'b1;
    n = 0;
    do begin tick(); n++; chk("late_no_req", 64'(cdc_req), 64'(0)); end
    while (s_ready && n < 20);
    chk("late_ready_low_edges", 64'(n), 64'(3));
    repeat (2) tick();
    @(negedge clk); ack_dir = 1'b0;
    n = 0;
    do begin tick(); n++; chk("late_no_req", 64'(cdc_req), 64'(0)); end
    while (!s_ready && n < 20);
    chk("late_ready_high_edges", 64'(n), 64'(3));
    chk("late_err_sticky", 64'(timeout_err), 64'(1));

    // async reset in the middle of a request
    send(32'hA5A5A5A5, 1'b0, ok);
    chk("rstmid_req", 64'(cdc_req), 64'(1));
    @(negedge clk); s_valid = 1'b0;
    @(posedge clk);
    #20 rstn = 1'b0;
    #1;
    chk("rstmid_req_low", 64'(cdc_req), 64'(0));
    chk("rstmid_data_zero", 64'(cdc_data), 64'(0));
    chk("rstmid_err_zero", 64'(timeout_err), 64'(0));
    @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    tick();
    chk("rstmid_ready_after", 64'(s_ready), 64'(1));

    // second timeout with err_clr held: set wins, then clear takes effect
    @(negedge clk); err_clr = 1'b1;
    send(32'h0BADF00D, 1'b0, ok);
    @(negedge clk); s_valid = 1'b0;
    n = 1;
    while (n < 40) begin
      tick();
      if (cdc_req) n++;
      else break;
    end
    chk("tmo2_req_cycles", 64'(n), 64'(16));
    chk("tmo2_set_wins", 64'(timeout_err), 64'(1));
    tick();
    chk("tmo2_cleared", 64'(timeout_err), 64'(0));
    @(negedge clk); err_clr = 1'b0;
    wait_idle("idle_before_b2b");

    // back-to-back with the destination responder
    dest_en = 1'b1; dhalf = 18;
    base = rx_log.size();
    for (int i = 1; i <= 3; i++) begin
      send(DW'(i), 1'b0, ok);
    end
    @(negedge clk); s_valid = 1'b0;
    wait_idle("idle_after_b2b");
    chk("b2b_count", 64'(rx_log.size() - base), 64'(3));
    if (rx_log.size() - base == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_word", 64'(rx_log[base + i]), 64'(i + 1));
    end

    // randomised transfers at slow then fast destination clock
    base = n_rx;
    for (int i = 0; i < 1000 && !abort; i++) begin
      dhalf = (i < 500) ? 136 : 18;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); s_valid = 1'b0; s_data = DW'($urandom);
      end
      send(DW'($urandom), 1'b1, ok);
      if (!ok) abort = 1'b1;
    end
    @(negedge clk); s_valid = 1'b0;
    wait_idle("idle_after_random");
    chk("rand_rx_count", 64'(n_rx - base), 64'(1000));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("rand_no_timeout", 64'(timeout_err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
